// File: rtl/reg_reader_pkg.sv
// reg_reader_pkg: shared types and widths for the sequential register-file reader.
package reg_reader_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    // Wide enough to hold a full 32-register run.
    localparam int REM_W      = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Next register number, wrapping mod 32 in either direction.
    function automatic logic [REG_ADDR_W-1:0] step_addr(input logic [REG_ADDR_W-1:0] addr,
                                                        input logic ascending);
        return ascending ? addr + 1'b1 : addr - 1'b1;
    endfunction

endpackage

// File: rtl/reg_reader_slot.sv
// reg_reader_slot: single-entry output holding register for the read stream.
// A load and an accept on the same edge keep valid high with the new word,
// so the stream runs without bubbles.
module reg_reader_slot
    import reg_reader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              accept,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    // Hold the captured word until the consumer takes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_valid && accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_reader.sv
// reg_reader: walks COUNT consecutive register numbers from a start register,
// ascending or descending with mod-32 wrap, and streams each value out on a
// valid/ready interface.
// Optional feature: define REG_READER_SUM_EN to add the running `sum` output.
module reg_reader
    import reg_reader_pkg::*;
#(
    parameter int COUNT = 6
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  direction,
    input  logic [REG_ADDR_W-1:0] start,
    output logic [REG_ADDR_W-1:0] regnum,
    input  logic [DATA_W-1:0]     reg_data,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef REG_READER_SUM_EN
    output logic [DATA_W-1:0]     sum,
`endif
    output logic                  done
);

    state_t           state;
    logic [REM_W-1:0] remaining;
    logic             dir_reg;
    logic             capture;

    // A new word may enter the slot when it is empty or being drained this edge.
    assign capture = (state == READ) && (!out_valid || out_ready);

    reg_reader_slot u_slot (
        .clock     (clock),
        .reset     (reset),
        .load      (capture),
        .load_data (reg_data),
        .accept    (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    // Run control: latch run parameters, step the address, count down, finish.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b1;
            regnum    <= '0;
            remaining <= '0;
            dir_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        dir_reg   <= direction;
                        regnum    <= start;
                        remaining <= REM_W'(COUNT);
                        done      <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (capture) begin
                        regnum    <= step_addr(regnum, dir_reg);
                        remaining <= remaining - 1'b1;
                        if (remaining == REM_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The slot clears valid on this same accept.
                    if (out_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef REG_READER_SUM_EN
    // Running total of accepted words; restarts on each accepted go.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (state == IDLE && go) begin
            sum <= '0;
        end else if (out_valid && out_ready) begin
            sum <= sum + out_data;
        end
    end
`endif

endmodule

// File: tb/tb_reg_reader.sv
// tb_reg_reader: directed self-checking bench for reg_reader (COUNT = 6).
module tb_reg_reader;

    localparam int COUNT = 6;

    logic        clock;
    logic        reset;
    logic        go;
    logic        direction;
    logic [4:0]  start;
    logic [4:0]  regnum;
    logic [31:0] reg_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        done;
`ifdef REG_READER_SUM_EN
    logic [31:0] sum;
`endif

    logic [31:0] rf [32];
    int          passed;
    int          total;

    assign reg_data = rf[regnum];

    reg_reader #(.COUNT(COUNT)) dut (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .direction (direction),
        .start     (start),
        .regnum    (regnum),
        .reg_data  (reg_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef REG_READER_SUM_EN
        .sum       (sum),
`endif
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            passed++;
        end
    endtask

    // One run: go pulse, then scoreboard every word until done.
    // stall_at/stall_n: hold out_ready low stall_n cycles while word stall_at is shown.
    // mess: pulse go and flip direction mid-run. abort_after: reset after that many words.
    task automatic do_run(input logic [4:0] st, input logic d, input int stall_at,
                          input int stall_n, input bit mess, input int abort_after);
        logic [4:0]  a;
        logic [31:0] exp_sum;
        int          words;
        int          cycles;
        int          stall_left;
        a          = st;
        exp_sum    = '0;
        words      = 0;
        cycles     = 0;
        stall_left = stall_n;
        @(negedge clock);
        start     = st;
        direction = d;
        out_ready = 1'b1;
        go        = 1'b1;
        @(posedge clock);
        @(negedge clock);
        go = 1'b0;
        chk("regnum_at_start", {27'd0, regnum}, {27'd0, st});
        chk("done_low_in_run", {31'd0, done}, 32'd0);
        while (cycles < 300) begin
            @(posedge clock);
            @(negedge clock);
            cycles++;
            if (done) break;
            if (abort_after >= 0 && words == abort_after) begin
                reset = 1'b1;
                #1;
                chk("abort_done", {31'd0, done}, 32'd1);
                chk("abort_valid", {31'd0, out_valid}, 32'd0);
                chk("abort_regnum", {27'd0, regnum}, 32'd0);
                @(negedge clock);
                reset = 1'b0;
                go = 1'b0;
                direction = d;
                $display("run start=%0d aborted after %0d words", st, words);
                return;
            end
            if (mess) begin
                go        = (words == 2);
                direction = (words >= 2) ? ~d : d;
            end
            if (out_valid) begin
                chk($sformatf("word_r%0d", a), out_data, rf[a]);
                if (words == stall_at && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    $display("word %0d addr=%0d data=0x%0h", words, a, rf[a]);
                    exp_sum = exp_sum + rf[a];
                    words++;
                    a = d ? a + 5'd1 : a - 5'd1;
                end
            end
        end
        go = 1'b0;
        direction = d;
        out_ready = 1'b1;
        chk("word_count", words, COUNT);
        chk("latency", cycles, COUNT + 1 + stall_n);
        chk("valid_after_done", {31'd0, out_valid}, 32'd0);
`ifdef REG_READER_SUM_EN
        chk("sum", sum, exp_sum);
`endif
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        go        = 1'b0;
        direction = 1'b1;
        start     = 5'd0;
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) rf[k] = 32'hd00 + k;
        rf[0] = 32'd0;

        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_done", {31'd0, done}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_regnum", {27'd0, regnum}, 32'd0);
`ifdef REG_READER_SUM_EN
        chk("rst_sum", sum, 32'd0);
`endif
        reset = 1'b0;

        // Ascending from r5: 0xd05..0xd0a back to back.
        do_run(5'd5, 1'b1, -1, 0, 1'b0, -1);
        // Descending from r1 with wrap: r1, r0 (=0), r31..r28.
        do_run(5'd1, 1'b0, -1, 0, 1'b0, -1);
        // Three-cycle consumer stall on word 2.
        do_run(5'd5, 1'b1, 2, 3, 1'b0, -1);
        // Mid-run go and direction toggles are ignored.
        do_run(5'd30, 1'b1, -1, 0, 1'b1, -1);
        // Reset after the third word, then a clean restart.
        do_run(5'd5, 1'b1, -1, 0, 1'b0, 3);
        do_run(5'd5, 1'b1, -1, 0, 1'b0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
